// File: rtl/layer_controller.sv
// layer_controller: sequences one fully-connected layer: weight/bias config, input broadcast, result collection, result drain.
// Latency: config pulses and broadcast samples appear 1 cycle after their handshake; one result per accepted out beat.
// Backpressure: cfg_ready only in IDLE, in_ready only in IDLE/FEED; out_data holds while out_valid && !out_ready.
// Optional build macro LAYER_TIMEOUT_EN: WAIT watchdog of timeoutCycles sets sticky err and drains with missing results as 0.
module layer_controller #(
   parameter int layerNo       = 0,
   parameter int numNeuron     = 30,
   parameter int numWeight     = 784,
   parameter int dataWidth     = 16,
   parameter int timeoutCycles = 4096
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cfg_valid,
   output logic                           cfg_ready,
   input  logic                           cfg_is_bias,
   input  logic [31:0]                    cfg_layer,
   input  logic [31:0]                    cfg_neuron,
   input  logic [31:0]                    cfg_data,
   output logic                           weightValid,
   output logic                           biasValid,
   output logic [31:0]                    weightValue,
   output logic [31:0]                    biasValue,
   output logic [31:0]                    configLayerNum,
   output logic [31:0]                    configNeuronNum,
   input  logic [dataWidth-1:0]           in_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic [dataWidth-1:0]           myInput,
   output logic                           myInputValid,
   input  logic [numNeuron*dataWidth-1:0] n_out,
   input  logic [numNeuron-1:0]           n_outvalid,
   output logic [dataWidth-1:0]           out_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           out_last,
   output logic                           busy,
   output logic                           err
);

   localparam int CW = $clog2(numWeight + 1);
   localparam int IW = (numNeuron > 1) ? $clog2(numNeuron) : 1;

   typedef enum logic [1:0] {IDLE, FEED, WAIT, DRAIN} state_t;

   state_t               state;
   state_t               state_nxt;
   logic [CW-1:0]        cnt;
   logic [IW-1:0]        idx;
   logic [numNeuron-1:0] done;
   logic [dataWidth-1:0] res [numNeuron];
   logic                 cfg_fire;
   logic                 in_fire;
   logic                 out_fire;
   logic                 all_done;
   logic                 last_sample;
   logic                 timeout_hit;

   // Elaboration-time parameter check; the message carries the layer index for debug.
   if (numNeuron < 1 || numWeight < 1 || dataWidth < 1 || timeoutCycles < 1 || layerNo < 0) begin : g_bad_cfg
      $error("layer_controller: invalid parameters for layer %0d", layerNo);
   end

   assign cfg_fire    = cfg_valid && cfg_ready;
   assign in_fire     = in_valid && in_ready;
   assign out_fire    = out_valid && out_ready;
   assign all_done    = &done;
   assign last_sample = (cnt == CW'(numWeight - 1));
   assign busy        = (state != IDLE);
   assign out_data    = res[idx];
   assign out_last    = (state == DRAIN) && (idx == IW'(numNeuron - 1));

`ifdef LAYER_TIMEOUT_EN
   localparam int TW = $clog2(timeoutCycles + 1);

   logic [TW-1:0] wait_cnt;
   logic          err_q;

   assign timeout_hit = (state == WAIT) && !all_done && (wait_cnt == TW'(timeoutCycles - 1));
   assign err         = err_q;

   // WAIT watchdog: counter is held at 0 outside WAIT so it restarts on every entry; err is sticky.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;
         else               wait_cnt <= '0;
         if (timeout_hit)   err_q    <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign err         = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next state and handshake outputs; config has priority over input in IDLE.
   always_comb begin
      state_nxt = state;
      cfg_ready = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            cfg_ready = 1'b1;
            in_ready  = !cfg_valid;
            if (in_valid && !cfg_valid) state_nxt = (numWeight == 1) ? WAIT : FEED;
         end
         FEED: begin
            in_ready = 1'b1;
            if (in_valid && last_sample) state_nxt = WAIT;
         end
         WAIT: begin
            if (all_done || timeout_hit) state_nxt = DRAIN;
         end
         DRAIN: begin
            out_valid = 1'b1;
            if (out_ready && out_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Config beat capture and the one-cycle weight/bias strobes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         weightValid     <= 1'b0;
         biasValid       <= 1'b0;
         weightValue     <= '0;
         biasValue       <= '0;
         configLayerNum  <= '0;
         configNeuronNum <= '0;
      end else begin
         weightValid <= cfg_fire && !cfg_is_bias;
         biasValid   <= cfg_fire && cfg_is_bias;
         if (cfg_fire) begin
            weightValue     <= cfg_data;
            biasValue       <= cfg_data;
            configLayerNum  <= cfg_layer;
            configNeuronNum <= cfg_neuron;
         end
      end
   end

   // Input broadcast (one cycle after accept) and per-vector sample count; the IDLE accept is sample 0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         myInput      <= '0;
         myInputValid <= 1'b0;
         cnt          <= '0;
      end else begin
         myInputValid <= in_fire;
         if (in_fire) begin
            myInput <= in_data;
            if (state == IDLE)    cnt <= CW'(1);
            else if (last_sample) cnt <= '0;
            else                  cnt <= cnt + 1'b1;
         end
      end
   end

   // Result capture while waiting, then indexed drain; results clear after the last beat so absent neurons read 0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         done <= '0;
         idx  <= '0;
         for (int k = 0; k < numNeuron; k++) res[k] <= '0;
      end else begin
         if (state == WAIT) begin
            idx <= '0;
            for (int k = 0; k < numNeuron; k++) begin
               if (n_outvalid[k]) begin
                  res[k]  <= n_out[k*dataWidth +: dataWidth];
                  done[k] <= 1'b1;
               end
            end
         end
         if (out_fire) begin
            if (out_last) begin
               idx  <= '0;
               done <= '0;
               for (int k = 0; k < numNeuron; k++) res[k] <= '0;
            end else begin
               idx <= idx + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_layer_controller.sv
// tb_layer_controller: directed stimulus for layer_controller with a transaction-level model checked every cycle.
// Latency: model expects strobes/broadcast one cycle after each handshake; results once every neuron answered.
// Backpressure: bench stalls out_ready mid-drain and collides config with input in IDLE.
module tb_layer_controller;

   localparam int NN = 3;
   localparam int NW = 4;
   localparam int DW = 16;
   localparam int TO = 8;
`ifdef LAYER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic             cfg_is_bias = 1'b0;
   logic [31:0]      cfg_layer = '0;
   logic [31:0]      cfg_neuron = '0;
   logic [31:0]      cfg_data = '0;
   logic             weightValid, biasValid;
   logic [31:0]      weightValue, biasValue, configLayerNum, configNeuronNum;
   logic [DW-1:0]    in_data = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [DW-1:0]    myInput;
   logic             myInputValid;
   logic [NN*DW-1:0] n_out = '0;
   logic [NN-1:0]    n_outvalid = '0;
   logic [DW-1:0]    out_data;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic             out_last;
   logic             busy;
   logic             err;

   layer_controller #(
      .layerNo(0), .numNeuron(NN), .numWeight(NW), .dataWidth(DW), .timeoutCycles(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_is_bias(cfg_is_bias),
      .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron), .cfg_data(cfg_data),
      .weightValid(weightValid), .biasValid(biasValid),
      .weightValue(weightValue), .biasValue(biasValue),
      .configLayerNum(configLayerNum), .configNeuronNum(configNeuronNum),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .myInput(myInput), .myInputValid(myInputValid),
      .n_out(n_out), .n_outvalid(n_outvalid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   // phase: 0 idle, 1 feeding, 2 waiting for results, 3 draining
   int          m_ph = 0;
   int          m_cnt = 0;
   int          m_idx = 0;
   int          m_wait = 0;
   bit          m_got [NN];
   logic [DW-1:0] m_val [NN];
   bit          chk_en = 1'b0;
   logic        e_wv = 0, e_bv = 0, e_miv = 0, e_err = 0;
   logic [31:0] e_w = 0, e_b = 0, e_lay = 0, e_neu = 0;
   logic [DW-1:0] e_mi = 0;

   function automatic logic exp_in_ready();
      return (m_ph == 1) || (m_ph == 0 && !cfg_valid);
   endfunction

   always @(posedge clk) begin : mdl
      logic acc_cfg, acc_in, acc_out, all_got;
      if (!rst) begin
         chk_en = 1'b1;
         m_ph = 0; m_cnt = 0; m_idx = 0; m_wait = 0;
         e_wv = 0; e_bv = 0; e_miv = 0; e_err = 0;
         e_w = 0; e_b = 0; e_lay = 0; e_neu = 0; e_mi = 0;
         for (int k = 0; k < NN; k++) begin m_got[k] = 0; m_val[k] = 0; end
      end else begin
         acc_cfg = (m_ph == 0) && cfg_valid;
         acc_in  = in_valid && exp_in_ready();
         acc_out = (m_ph == 3) && out_ready;
         all_got = 1'b1;
         for (int k = 0; k < NN; k++) all_got &= m_got[k];
         e_wv  = acc_cfg && !cfg_is_bias;
         e_bv  = acc_cfg && cfg_is_bias;
         if (acc_cfg) begin e_w = cfg_data; e_b = cfg_data; e_lay = cfg_layer; e_neu = cfg_neuron; end
         e_miv = acc_in;
         if (acc_in) e_mi = in_data;
         case (m_ph)
            0: if (acc_in) begin m_cnt = 1; m_wait = 0; m_ph = (m_cnt == NW) ? 2 : 1; end
            1: if (acc_in) begin m_cnt++; if (m_cnt == NW) begin m_ph = 2; m_wait = 0; end end
            2: begin
               if (all_got) begin m_ph = 3; m_idx = 0; end
               else if (TO_EN && m_wait == TO - 1) begin e_err = 1; m_ph = 3; m_idx = 0; end
               else m_wait++;
               for (int k = 0; k < NN; k++)
                  if (n_outvalid[k]) begin m_got[k] = 1; m_val[k] = n_out[k*DW +: DW]; end
            end
            3: if (acc_out) begin
               if (m_idx == NN - 1) begin
                  m_ph = 0;
                  for (int k = 0; k < NN; k++) begin m_got[k] = 0; m_val[k] = 0; end
               end else m_idx++;
            end
            default: m_ph = 0;
         endcase
      end
   end

   // ---------------- per-cycle compare and collection ----------------
   logic [DW-1:0] got_in [$];
   logic [DW-1:0] got_out [$];
   int            wv_cnt = 0, bv_cnt = 0;
   bit            last_seen = 0;
   logic [DW-1:0] last_dat = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cfg_ready", cfg_ready, m_ph == 0);
         chk("in_ready", in_ready, exp_in_ready());
         chk("weightValid", weightValid, e_wv);
         chk("biasValid", biasValid, e_bv);
         chk("weightValue", weightValue, e_w);
         chk("biasValue", biasValue, e_b);
         chk("configLayerNum", configLayerNum, e_lay);
         chk("configNeuronNum", configNeuronNum, e_neu);
         chk("myInputValid", myInputValid, e_miv);
         chk("myInput", myInput, e_mi);
         chk("busy", busy, m_ph != 0);
         chk("out_valid", out_valid, m_ph == 3);
         chk("err", err, e_err);
         if (m_ph == 3) begin
            chk("out_data", out_data, m_got[m_idx] ? m_val[m_idx] : '0);
            chk("out_last", out_last, m_idx == NN - 1);
         end
      end
      if (rst) begin
         if (myInputValid) got_in.push_back(myInput);
         if (weightValid) wv_cnt++;
         if (biasValid) bv_cnt++;
         if (out_valid && out_ready) begin
            got_out.push_back(out_data);
            if (out_last) begin last_seen = 1; last_dat = out_data; end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic feed4(input logic [DW-1:0] a, b, c, d);
      logic [DW-1:0] v [4];
      v[0] = a; v[1] = b; v[2] = c; v[3] = d;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin in_data = v[i]; step(); end
      in_valid = 1'b0;
   endtask

   task automatic respond(input logic [NN-1:0] m, input logic [DW-1:0] v0, v1, v2);
      n_outvalid = m; n_out = {v2, v1, v0};
      step();
      n_outvalid = '0;
   endtask

   task automatic wait_out_valid(input string nm);
      for (int i = 0; i < 30 && !out_valid; i++) step();
      chk(nm, out_valid, 1'b1);
   endtask

   task automatic drain_all(input string nm);
      last_seen = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 30 && !last_seen; i++) step();
      out_ready = 1'b0;
      chk(nm, last_seen, 1'b1);
   endtask

   task automatic chk_vec(input string nm, input logic [DW-1:0] a, b, c, d);
      chk({nm, "_n"}, got_in.size(), 4);
      if (got_in.size() == 4) begin
         chk({nm, "_s0"}, got_in[0], a); chk({nm, "_s1"}, got_in[1], b);
         chk({nm, "_s2"}, got_in[2], c); chk({nm, "_s3"}, got_in[3], d);
      end
   endtask

   task automatic chk_out(input string nm, input logic [DW-1:0] a, b, c);
      chk({nm, "_n"}, got_out.size(), 3);
      if (got_out.size() == 3) begin
         chk({nm, "_r0"}, got_out[0], a); chk({nm, "_r1"}, got_out[1], b); chk({nm, "_r2"}, got_out[2], c);
      end
      chk({nm, "_last"}, last_dat, c);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin : main
      int wv0;
      step(); step();
      rst = 1'b1;
      @(negedge clk);
      chk("rst_cfg_ready", cfg_ready, 1); chk("rst_busy", busy, 0); chk("rst_out_valid", out_valid, 0);
      chk("rst_miv", myInputValid, 0); chk("rst_wv", weightValid, 0); chk("rst_err", err, 0);

      // 1: weight then bias beat
      step();
      cfg_valid = 1; cfg_is_bias = 0; cfg_layer = 1; cfg_neuron = 2; cfg_data = 32'h5;
      step();
      cfg_is_bias = 1; cfg_neuron = 0; cfg_data = 32'h100;
      @(negedge clk);
      chk("t1_wv", weightValid, 1); chk("t1_neuron", configNeuronNum, 2); chk("t1_wval", weightValue, 5);
      step();
      cfg_valid = 0;
      @(negedge clk);
      chk("t1_bv", biasValid, 1); chk("t1_bval", biasValue, 32'h100); chk("t1_layer", configLayerNum, 1);
      step(); step();
      @(negedge clk);
      chk("t1_wv_count", wv_cnt, 1); chk("t1_bv_count", bv_cnt, 1);

      // 2: back-to-back feed, then all neurons answer together
      step();
      got_in.delete();
      feed4(16'd1, 16'd2, 16'd3, 16'd4);
      step();
      @(negedge clk);
      chk_vec("t2", 16'd1, 16'd2, 16'd3, 16'd4);
      chk("t2_in_ready", in_ready, 0); chk("t2_busy", busy, 1);
      step();
      respond(3'b111, 16'h0A, 16'h0B, 16'h0C);
      wait_out_valid("t2_wait_drain");
      got_out.delete();
      drain_all("t2_drain_done");
      chk_out("t2", 16'h0A, 16'h0B, 16'h0C);

      // 3: config collides with the first sample, gapped input, config attempt during FEED
      wv0 = wv_cnt;
      got_in.delete();
      cfg_valid = 1; cfg_is_bias = 0; cfg_layer = 1; cfg_neuron = 1; cfg_data = 32'h7;
      in_valid = 1; in_data = 16'h11;
      @(negedge clk);
      chk("t3_collision_in_ready", in_ready, 0);
      step(); cfg_valid = 0; in_valid = 0;
      step(); in_valid = 1; in_data = 16'h11;
      step(); in_data = 16'h12;
      step(); in_valid = 0; cfg_valid = 1; cfg_data = 32'h99;
      step(); cfg_valid = 0; in_valid = 1; in_data = 16'h13;
      step(); in_data = 16'h14;
      step(); in_valid = 0;
      step();
      @(negedge clk);
      chk_vec("t3", 16'h11, 16'h12, 16'h13, 16'h14);
      chk("t3_wv_count", wv_cnt - wv0, 1); chk("t3_wval", weightValue, 7); chk("t3_cfg_ready", cfg_ready, 0);

      // 4: out-of-order results and a two-cycle stall on the second beat
      step();
      respond(3'b100, 16'h0, 16'h0, 16'h30);
      step();
      respond(3'b001, 16'h10, 16'h0, 16'h0);
      respond(3'b010, 16'h0, 16'h20, 16'h0);
      got_out.delete();
      wait_out_valid("t4_wait_drain");
      out_ready = 1;
      step();
      out_ready = 0;
      @(negedge clk);
      chk("t4_hold1", out_data, 16'h20); chk("t4_hold1_vld", out_valid, 1);
      step();
      @(negedge clk);
      chk("t4_hold2", out_data, 16'h20);
      step();
      drain_all("t4_drain_done");
      chk_out("t4", 16'h10, 16'h20, 16'h30);
      chk("t4_idle_cfg_ready", cfg_ready, 1);

      // 5: reset in the middle of FEED, with input still offered during reset
      step();
      in_valid = 1; in_data = 16'h21;
      step(); in_data = 16'h22;
      step(); in_data = 16'h23; rst = 0;
      step();
      @(negedge clk);
      chk("t5_miv", myInputValid, 0); chk("t5_mi", myInput, 0); chk("t5_busy", busy, 0);
      chk("t5_wval", weightValue, 0); chk("t5_bval", biasValue, 0); chk("t5_layer", configLayerNum, 0);
      chk("t5_neuron", configNeuronNum, 0); chk("t5_out_valid", out_valid, 0); chk("t5_cfg_ready", cfg_ready, 1);
      step();
      rst = 1; in_valid = 0;
      got_in.delete();
      step();
      feed4(16'h31, 16'h32, 16'h33, 16'h34);
      step();
      @(negedge clk);
      chk_vec("t5", 16'h31, 16'h32, 16'h33, 16'h34);
      step();
      respond(3'b111, 16'h41, 16'h42, 16'h43);
      got_out.delete();
      wait_out_valid("t5_wait_drain");
      drain_all("t5_drain_done");
      chk_out("t5", 16'h41, 16'h42, 16'h43);

`ifdef LAYER_TIMEOUT_EN
      // 6: neuron 2 never answers; watchdog drains with a zero for it
      step();
      feed4(16'h1, 16'h2, 16'h3, 16'h4);
      respond(3'b011, 16'h51, 16'h52, 16'h0);
      got_out.delete();
      wait_out_valid("t6_wait_drain");
      chk("t6_err", err, 1);
      drain_all("t6_drain_done");
      chk_out("t6", 16'h51, 16'h52, 16'h0);
      step();
      @(negedge clk);
      chk("t6_err_sticky", err, 1);
`endif

      step(); step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
